sdram_arf_sched: RTL and testbench

//  Parametrised auto-refresh scheduler: next generation of the SDRAM refresh engine.
//  - Counts the refresh interval and queues owed refreshes, up to the JEDEC postponement limit.
//  - Requests the command bus from the SDRAM arbiter; after a grant, optionally issues PRECHARGE-ALL,

---
 rtl/sdram_arf_sched_pkg.sv | 36 +++
 rtl/sdram_arf_sched_ref_timer.sv | 49 ++++
 rtl/sdram_arf_sched.sv | 121 ++++++++++++
 tb/tb_sdram_arf_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arf_sched_pkg.sv
// Shared constants for the SDRAM auto-refresh scheduler: command encodings,
// default timing, FSM state type and the burst-length helper.
package sdram_arf_sched_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ARF = 4'b0001;

  localparam int DEF_REF_PERIOD = 780;
  localparam int DEF_T_RP       = 2;
  localparam int DEF_T_RFC      = 7;
  localparam int DEF_PRE_EN     = 1;
  localparam int DEF_REF_BURST  = 4;
  localparam int DEF_MAX_PEND   = 8;
  localparam int DEF_URGENT_TH  = 6;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_BANK_W     = 2;

  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WRP,
    ST_ARF,
    ST_WRFC,
    ST_DONE
  } state_t;

  // Number of refreshes to issue for one grant.
  function automatic logic [3:0] burst_len(input logic [3:0] pend, input logic [3:0] limit);
    return (pend < limit) ? pend : limit;
  endfunction

endpackage

// File: rtl/sdram_arf_sched_ref_timer.sv
// Refresh interval timer plus the owed-refresh counter with saturation and
// sticky overflow flag.
module sdram_arf_sched_ref_timer #(
  parameter int REF_PERIOD = 780,
  parameter int MAX_PEND   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       arf_issued,
  output logic [3:0] pend_cnt,
  output logic       pend_ovf
);

  localparam int TW = $clog2(REF_PERIOD + 1);

  logic [TW-1:0] timer;
  logic          tick;

  assign tick = init_done && (timer == TW'(REF_PERIOD));

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking assignments would create simulation/synthesis races.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
    end else begin
      if (!init_done)
        timer <= '0;
      else if (tick)
        timer <= TW'(1);
      else
        timer <= timer + 1'b1;

      // A tick and an issued refresh in the same cycle cancel out.
      if (tick && !arf_issued) begin
        if (pend_cnt == 4'(MAX_PEND))
          pend_ovf <= 1'b1;
        else
          pend_cnt <= pend_cnt + 1'b1;
      end else if (arf_issued && !tick && pend_cnt != '0) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arf_sched.sv
// Auto-refresh scheduler top: requests the bus, then issues an optional
// PRECHARGE-ALL followed by a burst of AUTO-REFRESH commands.
module sdram_arf_sched
  import sdram_arf_sched_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int T_RP       = DEF_T_RP,
  parameter int T_RFC      = DEF_T_RFC,
  parameter int PRE_EN     = DEF_PRE_EN,
  parameter int REF_BURST  = DEF_REF_BURST,
  parameter int MAX_PEND   = DEF_MAX_PEND,
  parameter int URGENT_TH  = DEF_URGENT_TH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BANK_W     = DEF_BANK_W
) (
  input  logic              Sys_clk,
  input  logic              Rst,
  input  logic              Init_done,
  output logic              Arf_req,
  output logic              Arf_urgent,
  input  logic              Arf_access,
  output logic              Arf_busy,
  output logic [3:0]        Command_ref,
  output logic [ADDR_W-1:0] Arf_a_addr,
  output logic [BANK_W-1:0] Arf_bank_addr,
  output logic              Ref_done,
  output logic [3:0]        Pend_cnt,
  output logic              Pend_ovf
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] issued;
  logic [3:0] burst_n;
  logic       grant;

  sdram_arf_sched_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .MAX_PEND   (MAX_PEND)
  ) u_timer (
    .clk        (Sys_clk),
    .rst        (Rst),
    .init_done  (Init_done),
    .arf_issued (state == ST_ARF),
    .pend_cnt   (Pend_cnt),
    .pend_ovf   (Pend_ovf)
  );

  assign Arf_req       = (state == ST_IDLE) && (Pend_cnt != '0) && Init_done;
  assign Arf_urgent    = (Pend_cnt >= 4'(URGENT_TH));
  assign grant         = Arf_access && Arf_req;
  assign Arf_busy      = grant || (state != ST_IDLE);
  assign Arf_bank_addr = '0;

  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      issued      <= '0;
      burst_n     <= '0;
      Command_ref <= CMD_NOP;
      Arf_a_addr  <= '0;
      Ref_done    <= 1'b0;
    end else begin
      // Command/address are registered and fall back to NOP/0 unless the
      // next state is PRE or ARF.
      Command_ref <= CMD_NOP;
      Arf_a_addr  <= '0;
      Ref_done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            burst_n <= burst_len(Pend_cnt, 4'(REF_BURST));
            issued  <= '0;
            if (PRE_EN != 0) begin
              state                <= ST_PRE;
              Command_ref          <= CMD_PRE;
              Arf_a_addr[A10_BIT]  <= 1'b1;
            end else begin
              state       <= ST_ARF;
              Command_ref <= CMD_ARF;
            end
          end
        end
        ST_PRE: begin
          state    <= ST_WRP;
          wait_cnt <= 8'(T_RP - 1);
        end
        ST_WRP: begin
          if (wait_cnt == '0) begin
            state       <= ST_ARF;
            Command_ref <= CMD_ARF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ARF: begin
          issued   <= issued + 1'b1;
          state    <= ST_WRFC;
          wait_cnt <= 8'(T_RFC - 1);
        end
        ST_WRFC: begin
          if (wait_cnt == '0) begin
            if (issued < burst_n) begin
              state       <= ST_ARF;
              Command_ref <= CMD_ARF;
            end else begin
              state    <= ST_DONE;
              Ref_done <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arf_sched.sv
// Self-checking bench for sdram_arf_sched: default instance (a_*) and a
// PRE_EN=0 / T_RFC=3 / short-period instance (b_*).
module tb_sdram_arf_sched;
  import sdram_arf_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_init, a_access, a_req, a_urgent, a_busy, a_done, a_ovf;
  logic [3:0]  a_cmd, a_pend;
  logic [11:0] a_addr;
  logic [1:0]  a_bank;
  logic        b_rst, b_init, b_access, b_req, b_urgent, b_busy, b_done, b_ovf;
  logic [3:0]  b_cmd, b_pend;
  logic [11:0] b_addr;
  logic [1:0]  b_bank;

  sdram_arf_sched dut_a (
    .Sys_clk(clk), .Rst(a_rst), .Init_done(a_init), .Arf_req(a_req),
    .Arf_urgent(a_urgent), .Arf_access(a_access), .Arf_busy(a_busy),
    .Command_ref(a_cmd), .Arf_a_addr(a_addr), .Arf_bank_addr(a_bank),
    .Ref_done(a_done), .Pend_cnt(a_pend), .Pend_ovf(a_ovf)
  );

  sdram_arf_sched #(.REF_PERIOD(20), .PRE_EN(0), .T_RFC(3)) dut_b (
    .Sys_clk(clk), .Rst(b_rst), .Init_done(b_init), .Arf_req(b_req),
    .Arf_urgent(b_urgent), .Arf_access(b_access), .Arf_busy(b_busy),
    .Command_ref(b_cmd), .Arf_a_addr(b_addr), .Arf_bank_addr(b_bank),
    .Ref_done(b_done), .Pend_cnt(b_pend), .Pend_ovf(b_ovf)
  );

  typedef struct {
    logic       access;
    logic [3:0] cmd;
    logic       a10;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[14];
  int   checks = 0;
  int   failures = 0;

  int n_pre, n_arf, done_rel, busy_cnt, addr_bad;
  int arf_rel[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grants one burst on the selected instance and records what it emits.
  task automatic capture(input bit sel, input int max_rel, input int init_low_at);
    logic [3:0]  cmd;
    logic [11:0] addr;
    n_pre = 0; n_arf = 0; done_rel = -1; busy_cnt = 0; addr_bad = 0;
    for (int k = 0; k < 8; k++) arf_rel[k] = -1;
    if (sel) b_access = 1'b1; else a_access = 1'b1;
    for (int rel = 0; rel <= max_rel; rel++) begin
      #1;
      cmd  = sel ? b_cmd : a_cmd;
      addr = sel ? b_addr : a_addr;
      if (sel ? b_busy : a_busy) busy_cnt++;
      if (cmd == CMD_PRE) begin
        n_pre++;
        if (addr != 12'h400) addr_bad++;
      end else if (addr != 12'h000) begin
        addr_bad++;
      end
      if (cmd == CMD_ARF) begin
        if (n_arf < 8) arf_rel[n_arf] = rel;
        n_arf++;
      end
      if (sel ? b_done : a_done) done_rel = rel;
      if (rel == init_low_at) a_init = 1'b0;
      cyc();
      a_access = 1'b0;
      b_access = 1'b0;
      if (done_rel >= 0) break;
    end
  endtask

  task automatic wait_pend_a(input logic [3:0] target, input int bound, input string name);
    int n = 0;
    while (a_pend != target && n < bound) begin cyc(); n++; end
    check(name, 32'(a_pend), 32'(target));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first_urg, first8, first_ovf;

    for (int i = 0; i < 14; i++) vecs[i] = '{1'b0, CMD_NOP, 1'b0, 1'b1, 1'b0};
    vecs[0].access = 1'b1;
    vecs[1].cmd    = CMD_PRE;
    vecs[1].a10    = 1'b1;
    vecs[4].cmd    = CMD_ARF;
    vecs[12].done  = 1'b1;
    vecs[13].busy  = 1'b0;

    a_rst = 1; a_init = 0; a_access = 0;
    b_rst = 1; b_init = 0; b_access = 0;
    cyc(); cyc();
    a_rst = 0; b_rst = 0;
    #1;
    check("rst_cmd", 32'(a_cmd), 32'(CMD_NOP));
    check("rst_pend", 32'(a_pend), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_req", 32'(a_req), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_addr", 32'({a_addr, a_bank}), 0);
    check("rst_cmd_b", 32'(b_cmd), 32'(CMD_NOP));

    // PRE_EN=0, T_RFC=3, two owed refreshes.
    b_init = 1;
    n = 0;
    while (b_pend != 4'd2 && n < 200) begin cyc(); n++; end
    check("t4_pend_start", 32'(b_pend), 2);
    capture(1'b1, 40, -1);
    check("t4_n_pre", n_pre, 0);
    check("t4_n_arf", n_arf, 2);
    check("t4_arf0", arf_rel[0], 1);
    check("t4_arf1", arf_rel[1], 5);
    check("t4_done", done_rel, 9);
    check("t4_busy", busy_cnt, 10);
    check("t4_pend_end", 32'(b_pend), 0);

    // Interval ticks, urgency, saturation and overflow without grants.
    a_init = 1;
    n = 0;
    while (!a_req && n < 1000) begin cyc(); n++; end
    check("t1_req_latency", n, 781);
    check("t1_pend1", 32'(a_pend), 1);
    first_urg = -1; first8 = -1; first_ovf = -1;
    while (n < 7100) begin
      if (a_urgent && first_urg < 0) first_urg = n;
      if (a_pend == 4'd8 && first8 < 0) first8 = n;
      if (a_ovf && first_ovf < 0) first_ovf = n;
      cyc(); n++;
    end
    check("t1_urgent_at", first_urg, 4681);
    check("t1_pend8_at", first8, 6241);
    check("t1_ovf_at", first_ovf, 7021);
    check("t1_pend_sat", 32'(a_pend), 8);

    a_rst = 1; cyc(); cyc(); a_rst = 0;
    #1;
    check("rst2_ovf", 32'(a_ovf), 0);

    // Single refresh with precharge, cycle by cycle.
    n = 0;
    while (!a_req && n < 1000) begin cyc(); n++; end
    check("t2_req", 32'(a_req), 1);
    for (int i = 0; i < 14; i++) begin
      a_access = vecs[i].access;
      #1;
      check($sformatf("t2_cmd[%0d]", i), 32'(a_cmd), 32'(vecs[i].cmd));
      check($sformatf("t2_a10[%0d]", i), 32'(a_addr[10]), 32'(vecs[i].a10));
      check($sformatf("t2_busy[%0d]", i), 32'(a_busy), 32'(vecs[i].busy));
      check($sformatf("t2_done[%0d]", i), 32'(a_done), 32'(vecs[i].done));
      cyc();
      a_access = 0;
    end
    check("t2_pend_end", 32'(a_pend), 0);

    // Backlog of six, burst limited to four.
    wait_pend_a(4'd6, 6000, "t3_pend_start");
    capture(1'b0, 60, -1);
    check("t3_n_pre", n_pre, 1);
    check("t3_n_arf", n_arf, 4);
    check("t3_arf0", arf_rel[0], 4);
    check("t3_arf1", arf_rel[1], 12);
    check("t3_arf2", arf_rel[2], 20);
    check("t3_arf3", arf_rel[3], 28);
    check("t3_done", done_rel, 36);
    check("t3_busy", busy_cnt, 37);
    check("t3_addr", addr_bad, 0);
    check("t3_pend_end", 32'(a_pend), 2);
    check("t3_req_after", 32'(a_req), 1);

    // Tick coincides with the first ARF: 3 -> 3 -> 2 -> 1.
    wait_pend_a(4'd3, 1000, "t5_pend_start");
    repeat (775) cyc();
    capture(1'b0, 60, -1);
    check("t5_n_arf", n_arf, 3);
    check("t5_arf0", arf_rel[0], 4);
    check("t5_pend_end", 32'(a_pend), 1);

    // Reset in the middle of WRFC.
    a_access = 1; cyc(); a_access = 0;
    repeat (5) cyc();
    a_rst = 1; cyc(); a_rst = 0;
    #1;
    check("t6_rst_cmd", 32'(a_cmd), 32'(CMD_NOP));
    check("t6_rst_pend", 32'(a_pend), 0);
    check("t6_rst_busy", 32'(a_busy), 0);

    // Grant with nothing owed is ignored.
    a_access = 1;
    #1;
    check("t5_nogrant_busy", 32'(a_busy), 0);
    cyc();
    a_access = 0;
    check("t5_nogrant_cmd", 32'(a_cmd), 32'(CMD_NOP));
    cyc();
    check("t5_nogrant_cmd2", 32'(a_cmd), 32'(CMD_NOP));

    // Init_done drops mid-burst: burst still completes, timer clears.
    n = 0;
    while (!a_req && n < 1000) begin cyc(); n++; end
    check("t6_req", 32'(a_req), 1);
    capture(1'b0, 30, 2);
    check("t6_done", done_rel, 12);
    check("t6_busy", busy_cnt, 13);
    check("t6_timer", 32'(dut_a.u_timer.timer), 0);
    check("t6_pend", 32'(a_pend), 0);
    check("t6_req_low", 32'(a_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
